// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        FETCH    = 2'd1,
        HOLD     = 2'd2,
        REDIRECT = 2'd3
    } pc_state_e;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'd0,
        SEL_INC  = 2'd1,
        SEL_TGT  = 2'd2,
        SEL_TRAP = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-pc mux: hold, increment, aligned branch target or trap vector.
module pc_next_sel
    import pc_seq_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] trap_vector,
    input  logic [1:0]      sel,
    output logic [XLEN-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_INC:  pc_next = pc + PC_INC;
            // Low two bits are dropped: fetch addresses are always word aligned.
            SEL_TGT:  pc_next = br_target & 32'hFFFF_FFFC;
            SEL_TRAP: pc_next = trap_vector;
            default:  pc_next = pc;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer with stall hold and branch redirect.
// Optional misaligned-target trap enabled by defining PC_TRAP_EN.
//
// state    | meaning
// BOOT     | one idle cycle after reset release, no fetch, branches ignored
// FETCH    | imem_req high, issue on ack unless stalled
// HOLD     | fetched instruction waiting for stall to drop
// REDIRECT | one bubble cycle after a taken branch
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
`ifdef PC_TRAP_EN
    output logic [XLEN-1:0] fetch_cnt,
    output logic            trap
`else
    output logic [XLEN-1:0] fetch_cnt
`endif
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    pc_sel_e         sel;

    pc_next_sel u_next_sel (
        .pc          (pc_q),
        .br_target   (br_target),
        .trap_vector (TRAP_VECTOR),
        .sel         (sel),
        .pc_next     (pc_d)
    );

    always_comb begin
        state_d  = state_q;
        sel      = SEL_HOLD;
        imem_req = 1'b0;
        pc_valid = 1'b0;
        flush    = 1'b0;
`ifdef PC_TRAP_EN
        trap     = 1'b0;
`endif
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (stall) begin
                        state_d = HOLD;
                    end else begin
                        pc_valid = 1'b1;
                        sel      = SEL_INC;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    pc_valid = 1'b1;
                    sel      = SEL_INC;
                    state_d  = FETCH;
                end
            end
            REDIRECT: state_d = FETCH;
            default:  state_d = BOOT;
        endcase

        // A taken branch overrides whatever the state decided above.
        if (br_taken && state_q != BOOT) begin
            pc_valid = 1'b0;
            flush    = 1'b1;
            state_d  = REDIRECT;
`ifdef PC_TRAP_EN
            if (br_target[1:0] != 2'b00) begin
                sel  = SEL_TRAP;
                trap = 1'b1;
            end else begin
                sel  = SEL_TGT;
            end
`else
            sel      = SEL_TGT;
`endif
        end

        fetch_cnt_d = fetch_cnt_q + {{(XLEN-1){1'b0}}, pc_valid};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule
